ioctl_dl_pacer: RTL
===================

Name: ioctl_dl_pacer

Overview:
- Sits directly upstream of the arcade core's ROM download port (dn_addr/dn_data/dn_wr).
- Takes the 48 MHz ioctl byte stream from the HPS side and buffers it in a small FIFO.
- Re-emits each byte as a dn_wr strobe stretched long enough for the core's 12 MHz domain to sample it.
- Applies ioctl_wait back-pressure so no byte is lost, and reports progress, an 8-bit checksum and errors.

Parameters:
- FIFO_DEPTH, 8, entries in the byte FIFO; power of two, minimum 4.
- ROM_INDEX, 8'd0, ioctl_index value accepted; other indices are ignored.
- WR_HOLD, 4, clk_48 cycles dn_wr stays high per byte; minimum 1.
- WR_GAP, 4, clk_48 cycles dn_wr stays low between strobes; minimum 1.

Ports:
- clk_48  in  1  system clock, 48 MHz.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download window active.
- ioctl_wr  in  1  one-cycle byte-valid strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  download target index.
- ioctl_wait  out  1  back-pressure to the ioctl source.
- dn_addr  out  16  core download address (ioctl_addr[15:0]).
- dn_data  out  8  core download data.
- dn_wr  out  1  stretched write strobe.
- dl_busy  out  1  download in progress or FIFO not drained.
- dl_done  out  1  one-cycle pulse when a download fully completes.
- byte_count  out  25  bytes accepted in the current download.
- checksum  out  8  modulo-256 sum of accepted bytes.
- overflow_err  out  1  sticky; a byte was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM in IDLE. The asynchronous assert forces dn_wr low immediately. Reset mid-download discards FIFO contents and all counters.
- Accept condition: ioctl_download & ioctl_wr & (ioctl_index == ROM_INDEX).
- Push: each accepted byte pushes {ioctl_addr[15:0], ioctl_dout} into the FIFO.
- Counters: byte_count += 1 and checksum += data (wraps at 8 bits) on every accepted byte. A byte dropped on overflow is still counted in both.
- Counter clear: byte_count and checksum clear on the rising edge of ioctl_download (registered edge detect). overflow_err also clears on that edge.
- ioctl_wait: registered; high when fill >= FIFO_DEPTH-2, low otherwise. The two-entry margin absorbs one in-flight write after wait asserts.
- Push while full: the byte is dropped and overflow_err is set (sticky).
- Simultaneous push and pop: fill is unchanged; pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE, SETUP, STROBE, GAP:
  - IDLE -> SETUP when the FIFO is not empty. The head is popped into dn_addr/dn_data; dn_wr stays 0.
  - SETUP -> STROBE after 1 cycle. dn_wr = 1 for exactly WR_HOLD cycles.
  - STROBE -> GAP. dn_wr = 0 for WR_GAP cycles.
  - GAP -> SETUP if the FIFO is not empty, else -> IDLE.
- dn_addr/dn_data hold their value from SETUP through the end of GAP; they change only in SETUP.
- Throughput: one byte per 1+WR_HOLD+WR_GAP cycles (9 at defaults).
- First-byte latency: accepted at cycle N -> SETUP at N+2 -> dn_wr rises at N+3.
- dl_busy = ioctl_download | FIFO non-empty | FSM != IDLE.
- dl_done: one-cycle pulse on the first cycle dl_busy falls from 1 to 0. A window in which no byte was accepted still pulses dl_done.
- ioctl_download dropping while the FIFO is non-empty: draining continues to completion; dl_done pulses after the last GAP.

Optional Feature:
- Macro DL_ADDR_CHECK_EN.
- When defined: adds output addr_err (1 bit, sticky, cleared with the counters). Sets when an accepted byte's ioctl_addr differs from previous accepted address + 1. The first byte of a download is exempt.
- When undefined: the port still exists and is tied to 0; no comparator logic is built.

Test Plan:
- Single byte, idx 0, addr 0x0000, data 0xA5 -> dn_wr high cycles N+3..N+6 with dn_addr = 0x0000, dn_data = 0xA5; checksum = 0xA5; byte_count = 1; dl_done pulses once after download falls.
- Burst of 32 bytes on consecutive cycles, source honours ioctl_wait -> 32 dn_wr strobes in order, spaced 9 cycles; ioctl_wait asserts at fill 6; overflow_err = 0; checksum matches the software sum mod 256.
- Same burst with the source ignoring ioctl_wait -> first 9 bytes accepted into the 8-entry FIFO/strobe path, later bytes dropped while full; overflow_err = 1; byte_count = 32.
- Writes with ioctl_index = 1 -> no FIFO push, no dn_wr, byte_count = 0, checksum = 0.
- reset_n low during a STROBE -> dn_wr = 0 in the same cycle; after release FIFO empty, dl_busy = 0, counters 0.
- DL_ADDR_CHECK_EN: addresses 0,1,2,5 -> addr_err sets on the 4th byte and stays set until the next download start.

Source files
------------

// File: rtl/ioctl_dl_pacer_if.sv
// ioctl_dl_pacer_if: groups the ioctl download stream, the core download
// port and the progress/status flags of the download pacer.
// master = ioctl source / core side, slave = the pacer itself.
interface ioctl_dl_pacer_if;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [7:0]  ioctl_index;
   logic        ioctl_wait;
   logic [15:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_wr;
   logic        dl_busy;
   logic        dl_done;
   logic [24:0] byte_count;
   logic [7:0]  checksum;
   logic        overflow_err;
   logic        addr_err;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
      input  ioctl_wait, dn_addr, dn_data, dn_wr, dl_busy, dl_done,
             byte_count, checksum, overflow_err, addr_err
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
      output ioctl_wait, dn_addr, dn_data, dn_wr, dl_busy, dl_done,
             byte_count, checksum, overflow_err, addr_err
   );
endinterface

// File: rtl/ioctl_dl_pacer.sv
// ioctl_dl_pacer: buffers the fast ioctl byte stream in a small FIFO and
// replays each byte to the core download port as a stretched dn_wr strobe
// (SETUP, WR_HOLD cycles high, WR_GAP cycles low), with ioctl_wait
// back-pressure, byte count, checksum and sticky error flags.
// Optional: define DL_ADDR_CHECK_EN to build the address-continuity
// checker driving addr_err; otherwise addr_err is tied low.
module ioctl_dl_pacer #(
   parameter int         FIFO_DEPTH = 8,
   parameter logic [7:0] ROM_INDEX  = 8'd0,
   parameter int         WR_HOLD    = 4,
   parameter int         WR_GAP     = 4
) (
   input  logic               clk_48,
   input  logic               reset_n,
   ioctl_dl_pacer_if.slave    bus
);

   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CNT_MAX = (WR_HOLD > WR_GAP) ? WR_HOLD : WR_GAP;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [AW:0] FILL_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] FILL_WAIT = (AW+1)'(FIFO_DEPTH - 2);
   localparam logic [CW-1:0] HOLD_LD = CW'(WR_HOLD - 1);
   localparam logic [CW-1:0] GAP_LD  = CW'(WR_GAP - 1);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   timer_q, timer_d;

   logic [23:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     fill_q, fill_d;
   logic            fifo_empty, fifo_full;

   logic [15:0]     dn_addr_q;
   logic [7:0]      dn_data_q;
   logic            dn_wr;

   logic            dl_prev_q, busy_prev_q, wait_q;
   logic [24:0]     byte_count_q;
   logic [7:0]      checksum_q;
   logic            overflow_q;

   logic            accept, dl_rise, push, pop, busy;

   assign accept     = bus.ioctl_download & bus.ioctl_wr & (bus.ioctl_index == ROM_INDEX);
   assign dl_rise    = bus.ioctl_download & ~dl_prev_q;
   assign fifo_empty = (fill_q == '0);
   assign fifo_full  = (fill_q == FILL_FULL);
   // A byte arriving while full is dropped even if a pop happens that cycle.
   assign push       = accept & ~fifo_full;

   // FSM state register: state and hold/gap timer.
   always_ff @(posedge clk_48 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   // FSM next state: pop the FIFO head whenever a new SETUP begins.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d = SETUP;
               pop     = 1'b1;
            end
         end
         SETUP: begin
            state_d = STROBE;
            timer_d = HOLD_LD;
         end
         STROBE: begin
            if (timer_q == '0) begin
               state_d = GAP;
               timer_d = GAP_LD;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         GAP: begin
            if (timer_q == '0) begin
               if (!fifo_empty) begin
                  state_d = SETUP;
                  pop     = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: strobe decoded from state so async reset drops it at once.
   always_comb begin
      dn_wr = (state_q == STROBE);
   end

   // FIFO storage: write port only, no reset so it maps onto RAM.
   always_ff @(posedge clk_48) begin
      if (push) mem[wr_ptr_q] <= {bus.ioctl_addr[15:0], bus.ioctl_dout};
   end

   // FIFO occupancy after this cycle's push/pop.
   always_comb begin
      fill_d = fill_q;
      unique case ({push, pop})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase
   end

   // FIFO pointers, fill level and registered back-pressure.
   always_ff @(posedge clk_48 or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         wait_q   <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         fill_q <= fill_d;
         wait_q <= (fill_d >= FILL_WAIT);
      end
   end

   // Registered FIFO read straight into the download address/data outputs.
   always_ff @(posedge clk_48 or negedge reset_n) begin
      if (!reset_n) begin
         dn_addr_q <= '0;
         dn_data_q <= '0;
      end else if (pop) begin
         {dn_addr_q, dn_data_q} <= mem[rd_ptr_q];
      end
   end

   // Progress counters; a new window clears them but still counts its first byte.
   always_ff @(posedge clk_48 or negedge reset_n) begin
      if (!reset_n) begin
         dl_prev_q    <= 1'b0;
         busy_prev_q  <= 1'b0;
         byte_count_q <= '0;
         checksum_q   <= '0;
         overflow_q   <= 1'b0;
      end else begin
         dl_prev_q    <= bus.ioctl_download;
         busy_prev_q  <= busy;
         byte_count_q <= (dl_rise ? 25'd0 : byte_count_q) + {24'd0, accept};
         checksum_q   <= (dl_rise ? 8'd0 : checksum_q) + (accept ? bus.ioctl_dout : 8'd0);
         overflow_q   <= (dl_rise ? 1'b0 : overflow_q) | (accept & fifo_full);
      end
   end

   assign busy = bus.ioctl_download | ~fifo_empty | (state_q != IDLE);

`ifdef DL_ADDR_CHECK_EN
   logic [24:0] prev_addr_q;
   logic        have_prev_q, addr_err_q, have_prev_eff;

   assign have_prev_eff = have_prev_q & ~dl_rise;

   // Address continuity: every accepted byte after the first must be prev+1.
   always_ff @(posedge clk_48 or negedge reset_n) begin
      if (!reset_n) begin
         prev_addr_q <= '0;
         have_prev_q <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         addr_err_q <= (dl_rise ? 1'b0 : addr_err_q) |
                       (accept & have_prev_eff & (bus.ioctl_addr != prev_addr_q + 25'd1));
         if (accept) begin
            prev_addr_q <= bus.ioctl_addr;
            have_prev_q <= 1'b1;
         end else if (dl_rise) begin
            have_prev_q <= 1'b0;
         end
      end
   end

   assign bus.addr_err = addr_err_q;
`else
   logic unused_addr_hi;
   assign unused_addr_hi = &{1'b0, bus.ioctl_addr[24:16]};
   assign bus.addr_err   = 1'b0;
`endif

   assign bus.ioctl_wait   = wait_q;
   assign bus.dn_addr      = dn_addr_q;
   assign bus.dn_data      = dn_data_q;
   assign bus.dn_wr        = dn_wr;
   assign bus.dl_busy      = busy;
   assign bus.dl_done      = busy_prev_q & ~busy;
   assign bus.byte_count   = byte_count_q;
   assign bus.checksum     = checksum_q;
   assign bus.overflow_err = overflow_q;

endmodule
